// File: rtl/axi_ram_slave_pkg.sv
// Shared definitions for the AXI RAM slave: response codes, FSM encodings
// and the burst length convention.
package axi_ram_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_BURST = 1'b1
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    // This codebase counts len directly as beats; zero still means one beat.
    function automatic logic [7:0] len_to_beats(input logic [7:0] len);
        return (len == 8'd0) ? 8'd1 : len;
    endfunction

endpackage

// File: rtl/axi_ram_slave_mem.sv
// Byte-writable word array: one registered read port, one strobed write port.
// A read and write of the same word on one edge returns the old contents.
module axi_ram_slave_mem #(
    parameter int WORDS = 4096,
    parameter int IDX_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [3:0]       wr_strb,
    input  logic [31:0]      wr_data
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI3-style RAM slave with independent single-outstanding read and write FSMs.
// Define AXI_RAM_SLAVE_DECERR_EN to return DECERR for addresses outside the array.
module axi_ram_slave
    import axi_ram_slave_pkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h1C00_0000
) (
    input  logic        Clk,
    input  logic        Rest,
    input  logic [3:0]  Arid,
    input  logic [31:0] Araddr,
    input  logic [7:0]  Arlen,
    input  logic [2:0]  Arsize,
    input  logic [1:0]  Arburst,
    input  logic [1:0]  Arlock,
    input  logic [3:0]  Arcache,
    input  logic [2:0]  Arprot,
    input  logic        Arvalid,
    output logic        Arready,
    output logic [3:0]  Rid,
    output logic [31:0] Rdata,
    output logic [1:0]  Rresp,
    output logic        Rlast,
    output logic        Rvalid,
    input  logic        Rready,
    input  logic [3:0]  Awid,
    input  logic [31:0] Awaddr,
    input  logic [7:0]  Awlen,
    input  logic [2:0]  Awsize,
    input  logic [1:0]  Awburst,
    input  logic [1:0]  Awlock,
    input  logic [3:0]  Awcache,
    input  logic [2:0]  Awprot,
    input  logic        Awvalid,
    output logic        Awready,
    input  logic [3:0]  Wid,
    input  logic [31:0] Wdata,
    input  logic [3:0]  Wstrb,
    input  logic        Wlast,
    input  logic        Wvalid,
    output logic        Wready,
    output logic [3:0]  Bid,
    output logic [1:0]  Bresp,
    output logic        Bvalid,
    input  logic        Bready,
    output logic        r_state_dbg,
    output logic [1:0]  w_state_dbg
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    // Handshake rule: a beat transfers on a rising edge where valid && ready;
    // valid holds its payload until then, and every ready here is a register.
    logic [31:0] ar_off, aw_off;
    logic        ar_err, aw_err;
    assign ar_off = Araddr - BASE_ADDR;
    assign aw_off = Awaddr - BASE_ADDR;

`ifdef AXI_RAM_SLAVE_DECERR_EN
    assign ar_err = (ar_off >> (IDX_W + 2)) != 32'd0;
    assign aw_err = (aw_off >> (IDX_W + 2)) != 32'd0;
`else
    assign ar_err = 1'b0;
    assign aw_err = 1'b0;
`endif

    logic unused_inputs;
    assign unused_inputs = ^{Arsize, Arburst, Arlock, Arcache, Arprot,
                             Awsize, Awburst, Awlock, Awcache, Awprot, Wid,
                             ar_off[1:0], ar_off[31:IDX_W+2],
                             aw_off[1:0], aw_off[31:IDX_W+2]};

    // ---------------- read side ----------------
    r_state_t         r_state, r_next;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_cnt;
    logic             r_err;
    logic             ar_hs, r_hs;
    logic [31:0]      mem_rdata;
    logic             mem_rd_en;
    logic [IDX_W-1:0] mem_rd_idx;

    assign ar_hs  = Arvalid & Arready;
    assign Rvalid = (r_state == R_BURST);
    assign r_hs   = Rvalid & Rready;
    assign Rlast  = Rvalid & (r_cnt == 8'd1);
    assign Rresp  = (Rvalid & r_err) ? RESP_DECERR : RESP_OKAY;
    assign Rdata  = (Rvalid & ~r_err) ? mem_rdata : 32'd0;
    assign r_state_dbg = r_state;

    // Fetch the first word at the address handshake, later words as each beat retires.
    assign mem_rd_en  = ar_hs | (r_hs & ~Rlast);
    assign mem_rd_idx = ar_hs ? ar_off[IDX_W+1:2] : r_idx + IDX_W'(1);

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)          r_next = R_BURST;
            R_BURST: if (r_hs && Rlast)  r_next = R_IDLE;
            default:                     r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            Arready <= 1'b0;
            Rid     <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            Arready <= (r_next == R_IDLE);
            if (ar_hs) begin
                Rid   <= Arid;
                r_idx <= ar_off[IDX_W+1:2];
                r_cnt <= len_to_beats(Arlen);
                r_err <= ar_err;
            end else if (r_hs && !Rlast) begin
                r_idx <= r_idx + IDX_W'(1);
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    // ---------------- write side ----------------
    w_state_t         w_state, w_next;
    logic [IDX_W-1:0] w_idx;
    logic [7:0]       w_cnt;
    logic             w_err;
    logic             aw_hs, w_hs, w_end;

    assign aw_hs  = Awvalid & Awready;
    assign Wready = (w_state == W_DATA);
    assign Bvalid = (w_state == W_RESP);
    assign w_hs   = Wvalid & Wready;
    assign w_end  = w_hs & (Wlast | (w_cnt == 8'd1));
    assign Bresp  = (Bvalid & w_err) ? RESP_DECERR : RESP_OKAY;
    assign w_state_dbg = w_state;

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs)  w_next = W_DATA;
            W_DATA:  if (w_end)  w_next = W_RESP;
            W_RESP:  if (Bready) w_next = W_IDLE;
            default:             w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            Awready <= 1'b0;
            Bid     <= '0;
            w_idx   <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else begin
            Awready <= (w_next == W_IDLE);
            if (aw_hs) begin
                Bid   <= Awid;
                w_idx <= aw_off[IDX_W+1:2];
                w_cnt <= len_to_beats(Awlen);
                w_err <= aw_err;
            end else if (w_hs) begin
                w_idx <= w_idx + IDX_W'(1);
                w_cnt <= w_cnt - 8'd1;
            end
        end
    end

    axi_ram_slave_mem #(
        .WORDS (MEM_WORDS),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk     (Clk),
        .rd_en   (mem_rd_en),
        .rd_idx  (mem_rd_idx),
        .rd_data (mem_rdata),
        .wr_en   (w_hs & ~w_err),
        .wr_idx  (w_idx),
        .wr_strb (Wstrb),
        .wr_data (Wdata)
    );

endmodule
